// File: rtl/mips_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mips_bus_arbiter
// Purpose  : Round-robin two-master / one-slave arbiter for the CPU memory bus.
//            Each grant is held for one complete transfer.
// Revision : 1.0  initial release
// ============================================================================
module mips_bus_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter bit FIRST_M = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_writedata,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  output logic                m0_waitrequest,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   readdata,
  output logic [ADDR_W-1:0]   s_address,
  output logic                s_read,
  output logic                s_write,
  output logic [DATA_W-1:0]   s_writedata,
  output logic [DATA_W/8-1:0] s_byteenable,
  input  logic                s_waitrequest,
  input  logic [DATA_W-1:0]   s_readdata,
  output logic [1:0]          owner
);

  // State encoding doubles as the owner debug code.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_OWN0 = 2'b01,
    ST_OWN1 = 2'b10
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   r_last;
  logic   w_last_nxt;
  logic   w_req0;
  logic   w_req1;

  assign w_req0 = m0_read | m0_write;
  assign w_req1 = m1_read | m1_write;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_last  <= ~FIRST_M;
    end else begin
      r_state <= w_state_nxt;
      r_last  <= w_last_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_last_nxt  = r_last;
    case (r_state)
      ST_IDLE: begin
        if (w_req0 && w_req1) begin
          w_state_nxt = r_last ? ST_OWN0 : ST_OWN1;
        end else if (w_req0) begin
          w_state_nxt = ST_OWN0;
        end else if (w_req1) begin
          w_state_nxt = ST_OWN1;
        end
      end
      ST_OWN0: begin
        // A withdrawn request releases the bus without counting as a turn.
        if (!w_req0) begin
          w_state_nxt = ST_IDLE;
        end else if (!s_waitrequest) begin
          w_state_nxt = ST_IDLE;
          w_last_nxt  = 1'b0;
        end
      end
      ST_OWN1: begin
        if (!w_req1) begin
          w_state_nxt = ST_IDLE;
        end else if (!s_waitrequest) begin
          w_state_nxt = ST_IDLE;
          w_last_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    s_address      = '0;
    s_read         = 1'b0;
    s_write        = 1'b0;
    s_writedata    = '0;
    s_byteenable   = '0;
    m0_waitrequest = 1'b1;
    m1_waitrequest = 1'b1;
    case (r_state)
      ST_OWN0: begin
        s_address      = m0_address;
        s_read         = m0_read;
        s_write        = m0_write;
        s_writedata    = m0_writedata;
        s_byteenable   = m0_byteenable;
        m0_waitrequest = s_waitrequest;
      end
      ST_OWN1: begin
        s_address      = m1_address;
        s_read         = m1_read;
        s_write        = m1_write;
        s_writedata    = m1_writedata;
        s_byteenable   = m1_byteenable;
        m1_waitrequest = s_waitrequest;
      end
      default: ;
    endcase
  end

  assign owner    = r_state;
  assign readdata = s_readdata;

endmodule
`default_nettype wire

// File: tb/tb_mips_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_bus_arbiter
// Purpose  : Directed and random checks of mips_bus_arbiter against a
//            transaction-level reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_mips_bus_arbiter;
  localparam bit FIRST_M = 1'b0;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] m0_address, m1_address, m0_writedata, m1_writedata;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] readdata, s_address, s_writedata, s_readdata;
  logic        s_read, s_write, s_waitrequest;
  logic [3:0]  s_byteenable;
  logic [1:0]  owner;

  always #5 clk = ~clk;

  mips_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .FIRST_M(FIRST_M)) dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable), .m0_waitrequest(m0_waitrequest),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable), .m1_waitrequest(m1_waitrequest),
    .readdata(readdata), .s_address(s_address), .s_read(s_read), .s_write(s_write),
    .s_writedata(s_writedata), .s_byteenable(s_byteenable),
    .s_waitrequest(s_waitrequest), .s_readdata(s_readdata), .owner(owner)
  );

  // Stimulus held per master; index 0 = data port, 1 = fetch port.
  logic        rd [2];
  logic        wr [2];
  logic [31:0] ad [2];
  logic [31:0] wd [2];
  logic [3:0]  be [2];
  logic        keep [2];
  logic        done [2];
  logic        swait;
  logic [31:0] srd;

  // Reference: who holds the bus (-1 none) and who completed most recently.
  int cur_owner = -1;
  int last_served = 1;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic apply();
    m0_read = rd[0]; m0_write = wr[0]; m0_address = ad[0]; m0_writedata = wd[0]; m0_byteenable = be[0];
    m1_read = rd[1]; m1_write = wr[1]; m1_address = ad[1]; m1_writedata = wd[1]; m1_byteenable = be[1];
    s_waitrequest = swait;
    s_readdata    = srd;
  endtask

  // One bus cycle: drive, check outputs against the model, clock, advance the model.
  task automatic step();
    int o;
    int prev;
    apply();
    #2;
    o = cur_owner;
    chk("owner", 64'(owner), (o < 0) ? 64'd0 : ((o == 0) ? 64'd1 : 64'd2));
    chk("s_read", 64'(s_read), (o < 0) ? 64'd0 : 64'(rd[o]));
    chk("s_write", 64'(s_write), (o < 0) ? 64'd0 : 64'(wr[o]));
    chk("s_address", 64'(s_address), (o < 0) ? 64'd0 : 64'(ad[o]));
    chk("s_writedata", 64'(s_writedata), (o < 0) ? 64'd0 : 64'(wd[o]));
    chk("s_byteenable", 64'(s_byteenable), (o < 0) ? 64'd0 : 64'(be[o]));
    chk("m0_wait", 64'(m0_waitrequest), (o == 0) ? 64'(swait) : 64'd1);
    chk("m1_wait", 64'(m1_waitrequest), (o == 1) ? 64'(swait) : 64'd1);
    chk("readdata", 64'(readdata), 64'(srd));
    @(posedge clk);
    prev = cur_owner;
    for (int i = 0; i < 2; i++)
      done[i] = !reset && (prev == i) && (rd[i] || wr[i]) && !swait;
    if (reset) begin
      cur_owner   = -1;
      last_served = FIRST_M ? 0 : 1;
    end else if (prev < 0) begin
      if ((rd[0] || wr[0]) && (rd[1] || wr[1])) cur_owner = 1 - last_served;
      else if (rd[0] || wr[0])                   cur_owner = 0;
      else if (rd[1] || wr[1])                   cur_owner = 1;
    end else if (!(rd[prev] || wr[prev])) begin
      cur_owner = -1;
    end else if (!swait) begin
      last_served = prev;
      cur_owner   = -1;
    end
    #1;
  endtask

  // Masters drop a finished request, or issue the next one if streaming.
  task automatic retire();
    for (int i = 0; i < 2; i++) begin
      if (done[i]) begin
        if (keep[i]) begin
          ad[i] = $urandom; wd[i] = $urandom;
        end else begin
          rd[i] = 1'b0; wr[i] = 1'b0;
        end
      end
    end
  endtask

  task automatic clear_all();
    for (int i = 0; i < 2; i++) begin
      rd[i] = 0; wr[i] = 0; ad[i] = '0; wd[i] = '0; be[i] = '0; keep[i] = 0; done[i] = 0;
    end
    swait = 0; srd = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    clear_all();
    reset = 1'b1;
    apply();
    @(posedge clk); #1;
    do_reset();

    // Lone fetch from the boot vector.
    rd[1] = 1; ad[1] = 32'hBFC0_0000; be[1] = 4'hF; srd = 32'h3C02_0000;
    for (int k = 0; k < 4; k++) begin
      step();
      retire();
    end

    // Simultaneous first requests after reset: data port must win.
    do_reset();
    rd[0] = 1; ad[0] = 32'h0000_1000; rd[1] = 1; ad[1] = 32'hBFC0_0004;
    swait = 1;
    step();
    chk("tie_first_owner", 64'(owner), 64'd1);
    for (int k = 0; k < 6; k++) begin
      swait = (k < 2);
      step();
      retire();
    end

    // Continuous requests from both: strict alternation.
    clear_all();
    do_reset();
    rd[0] = 1; rd[1] = 1; keep[0] = 1; keep[1] = 1; be[0] = 4'hF; be[1] = 4'hF;
    for (int k = 0; k < 12; k++) begin
      apply();
      #1;
      chk("rr_seq", 64'(owner), (k % 2 == 0) ? 64'd0 : (((k / 2) % 2 == 0) ? 64'd1 : 64'd2));
      step();
      retire();
    end

    // Stretched write from the data port while fetch is blocked.
    clear_all();
    do_reset();
    wr[0] = 1; ad[0] = 32'h0000_1000; wd[0] = 32'h0000_0205; be[0] = 4'hF;
    rd[1] = 1; ad[1] = 32'hBFC0_0008; be[1] = 4'hF;
    for (int k = 0; k < 7; k++) begin
      swait = (k >= 1 && k <= 3);
      step();
      retire();
    end

    // Reset while the fetch port owns a stalled transfer.
    clear_all();
    do_reset();
    rd[1] = 1; ad[1] = 32'hBFC0_0010; be[1] = 4'hF; swait = 1;
    step();
    step();
    reset = 1;
    step();
    reset = 0;
    rd[0] = 1; ad[0] = 32'h0000_2000;
    step();
    apply();
    #1;
    chk("post_reset_grant", 64'(owner), FIRST_M ? 64'd2 : 64'd1);
    step();

    // Random traffic with occasional withdrawals and resets.
    clear_all();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 59) == 0);
      swait = ($urandom_range(0, 2) == 0);
      srd   = $urandom;
      for (int i = 0; i < 2; i++) begin
        if (!(rd[i] || wr[i])) begin
          ad[i] = $urandom; wd[i] = $urandom; be[i] = 4'($urandom_range(0, 15));
          if ($urandom_range(0, 2) == 0) begin
            int op;
            op = $urandom_range(0, 9);
            rd[i] = (op < 5) || (op == 9);
            wr[i] = (op >= 5);
          end
        end else if ($urandom_range(0, 24) == 0) begin
          rd[i] = 0; wr[i] = 0;
        end
      end
      step();
      retire();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
